// File: rtl/frame_filter_pkg.sv
// Shared constants for the video pipeline: FSM encodings and RGB444 field positions
// used by the capture, filter and display blocks.
package frame_filter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int RED_HI = 11;
  localparam int RED_LO = 8;
  localparam int GRN_HI = 7;
  localparam int GRN_LO = 4;
  localparam int BLU_HI = 3;
  localparam int BLU_LO = 0;

  localparam logic FLUSH_LAST = 1'b1;

endpackage

// File: rtl/frame_filter_rgb444_to_gray.sv
// Combinational RGB444 to 4-bit luma approximation: gray = (2R + 5G + B) >> 3.
module rgb444_to_gray
  import frame_filter_pkg::*;
(
  input  logic [11:0] pix,
  output logic [3:0]  gray
);

  logic [6:0] sum_s;

  // Weighted sum fits in 7 bits (max 120); the top four bits form the result
  always_comb begin
    sum_s = ({3'b000, pix[RED_HI:RED_LO]} << 1)
          + ({3'b000, pix[GRN_HI:GRN_LO]} << 2)
          + {3'b000, pix[GRN_HI:GRN_LO]}
          + {3'b000, pix[BLU_HI:BLU_LO]};
    gray  = 4'(sum_s >> 3);
  end

endmodule

// File: rtl/frame_filter.sv
// Streams one frame from the frame buffer through a gray/threshold filter into the
// output buffer, counting pixels at or above the latched threshold.
module frame_filter
  import frame_filter_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic              bw_mode,
  input  logic [3:0]        thresh,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] white_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);

  logic [1:0]        state_r, state_next_s;
  logic              flush_cnt_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              bw_mode_r;
  logic [3:0]        thresh_r;
  logic              busy_r, done_r;
  logic              pipe_vld_r;
  logic [ADDR_W-1:0] pipe_addr_r;
  logic              wr_we_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [PIX_W-1:0]  wr_data_r;
  logic [ADDR_W-1:0] white_count_r;
  logic [3:0]        gray_s;
  logic              hit_s;
  logic [PIX_W-1:0]  pix_out_s;
  logic              launch_s;

  rgb444_to_gray u_gray (
    .pix  (rd_data[RED_HI:BLU_LO]),
    .gray (gray_s)
  );

  assign launch_s = (state_r == ST_IDLE) && start;

  // Next-state decode; start and ack only matter in IDLE and DONE respectively
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_next_s = ST_RUN; else state_next_s = ST_IDLE;
      ST_RUN:   if (rd_addr_r == LAST_ADDR) state_next_s = ST_FLUSH; else state_next_s = ST_RUN;
      ST_FLUSH: if (flush_cnt_r == FLUSH_LAST) state_next_s = ST_DONE; else state_next_s = ST_FLUSH;
      ST_DONE:  if (ack) state_next_s = ST_IDLE; else state_next_s = ST_DONE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output pixel select: binary threshold or replicated gray
  always_comb begin
    hit_s     = (gray_s >= thresh_r);
    pix_out_s = {PIX_W{1'b0}};
    if (bw_mode_r) begin
      if (hit_s) pix_out_s = PIX_W'(12'hFFF);
      else       pix_out_s = PIX_W'(12'h000);
    end else begin
      pix_out_s = PIX_W'({gray_s, gray_s, gray_s});
    end
  end

  // FSM, read address generator and per-frame configuration latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 1'b0;
      rd_addr_r   <= {ADDR_W{1'b0}};
      bw_mode_r   <= 1'b0;
      thresh_r    <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      busy_r      <= (state_next_s != ST_IDLE);
      done_r      <= (state_next_s == ST_DONE);
      flush_cnt_r <= (state_r == ST_FLUSH) ? (flush_cnt_r + 1'b1) : 1'b0;
      if (launch_s) begin
        rd_addr_r <= {ADDR_W{1'b0}};
        bw_mode_r <= bw_mode;
        thresh_r  <= thresh;
      end else if ((state_r == ST_RUN) && (rd_addr_r != LAST_ADDR)) begin
        rd_addr_r <= rd_addr_r + ADDR_ONE;
      end
    end
  end

  // Two-stage write pipeline matching the one-cycle frame-buffer read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_r    <= 1'b0;
      pipe_addr_r   <= {ADDR_W{1'b0}};
      wr_we_r       <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_data_r     <= {PIX_W{1'b0}};
      white_count_r <= {ADDR_W{1'b0}};
    end else begin
      pipe_vld_r  <= (state_r == ST_RUN);
      pipe_addr_r <= rd_addr_r;
      wr_we_r     <= pipe_vld_r;
      if (pipe_vld_r) begin
        wr_addr_r <= pipe_addr_r;
        wr_data_r <= pix_out_s;
      end
      if (launch_s) begin
        white_count_r <= {ADDR_W{1'b0}};
      end else if (pipe_vld_r && hit_s) begin
        white_count_r <= white_count_r + ADDR_ONE;
      end
    end
  end

  assign rd_addr     = rd_addr_r;
  assign wr_we       = wr_we_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign white_count = white_count_r;

endmodule

// File: tb/tb_frame_filter.sv
// Directed bench for frame_filter on a 4x2 image with a one-cycle-latency frame buffer model.
module tb_frame_filter;

  localparam int N  = 8;
  localparam int AW = 17;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          reset, start, ack, bw_mode;
  logic [3:0]    thresh;
  logic [AW-1:0] rd_addr, wr_addr, white_count;
  logic [PW-1:0] rd_data, wr_data;
  logic          wr_we, busy, done;

  logic [PW-1:0] fb    [N];
  logic [PW-1:0] exp_d [N];
  logic [PW-1:0] wr_log[N];
  int            wr_cnt[N];
  int            cyc = 0;
  int            n_chk = 0, n_pass = 0;
  int            first_we, last_we, n_wr;
  int            t0, tdone;
  logic [AW-1:0] wc_hold;

  frame_filter #(.IMG_W(4), .IMG_H(2), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .bw_mode(bw_mode),
    .thresh(thresh), .rd_addr(rd_addr), .rd_data(rd_data), .wr_we(wr_we),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .white_count(white_count)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= fb[rd_addr[2:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clr_log();
    for (int i = 0; i < N; i++) wr_cnt[i] = 0;
    first_we = -1;
    last_we  = -1;
    n_wr     = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (wr_we === 1'b1) begin
      n_wr++;
      if (int'(wr_addr) < N) begin
        wr_cnt[int'(wr_addr)]++;
        wr_log[int'(wr_addr)] = wr_data;
      end
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
    end
  endtask

  task automatic start_frame(input logic bw, input logic [3:0] th, output int ts);
    clr_log();
    start   = 1'b1;
    bw_mode = bw;
    thresh  = th;
    ts      = cyc;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(output int td);
    td = -1;
    for (int k = 0; k < 60; k++) begin
      if (done === 1'b1) begin
        td = cyc;
        break;
      end
      tick();
    end
    if (td < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify(input string tag, input int ts, input int td, input logic [AW-1:0] wc);
    chk({tag, "_first_we"}, first_we, ts + 3);
    chk({tag, "_last_we"},  last_we,  ts + 10);
    chk({tag, "_done_at"},  td,       ts + 11);
    chk({tag, "_n_wr"},     n_wr,     N);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i), wr_cnt[i], 1);
      chk($sformatf("%s_dat%0d", tag, i), wr_log[i], exp_d[i]);
    end
    chk({tag, "_white"}, white_count, wc);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic load_mixed();
    fb[0] = 12'hF00; fb[1] = 12'h0F0; fb[2] = 12'hFFF; fb[3] = 12'h000;
    fb[4] = 12'hF00; fb[5] = 12'h0F0; fb[6] = 12'hFFF; fb[7] = 12'h000;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ack = 1'b0; bw_mode = 1'b0; thresh = 4'd0;
    load_mixed();
    clr_log();
    tick(); tick();
    chk("rst_busy",  busy,        1'b0);
    chk("rst_done",  done,        1'b0);
    chk("rst_we",    wr_we,       1'b0);
    chk("rst_raddr", rd_addr,     17'd0);
    chk("rst_waddr", wr_addr,     17'd0);
    chk("rst_wdata", wr_data,     12'h000);
    chk("rst_white", white_count, 17'd0);
    reset = 1'b1;
    tick(); tick();

    // Grayscale frame, then done held without ack
    exp_d[0] = 12'h333; exp_d[1] = 12'h999; exp_d[2] = 12'hFFF; exp_d[3] = 12'h000;
    exp_d[4] = 12'h333; exp_d[5] = 12'h999; exp_d[6] = 12'hFFF; exp_d[7] = 12'h000;
    start_frame(1'b0, 4'd8, t0);
    chk("gray_busy", busy, 1'b1);
    chk("gray_raddr0", rd_addr, 17'd0);
    wait_done(tdone);
    verify("gray", t0, tdone, 17'd4);
    wc_hold = white_count;
    tick(); tick(); tick();
    chk("gray_done_hold", done, 1'b1);
    chk("gray_white_hold", white_count, wc_hold);
    chk("gray_no_we_done", n_wr, N);
    do_ack();
    chk("gray_ack_done", done, 1'b0);
    chk("gray_ack_busy", busy, 1'b0);

    // Binary frame with ack pulsed during RUN (ignored)
    for (int i = 0; i < 4; i++) begin
      fb[i] = 12'hF00; fb[i+4] = 12'h0F0;
      exp_d[i] = 12'h000; exp_d[i+4] = 12'hFFF;
    end
    start_frame(1'b1, 4'd8, t0);
    do_ack();
    wait_done(tdone);
    verify("bw", t0, tdone, 17'd4);
    do_ack();

    // Threshold and mode changed mid-RUN must not affect the frame
    load_mixed();
    exp_d[0] = 12'h000; exp_d[1] = 12'hFFF; exp_d[2] = 12'hFFF; exp_d[3] = 12'h000;
    exp_d[4] = 12'h000; exp_d[5] = 12'hFFF; exp_d[6] = 12'hFFF; exp_d[7] = 12'h000;
    start_frame(1'b1, 4'd8, t0);
    tick();
    thresh  = 4'd2;
    bw_mode = 1'b0;
    wait_done(tdone);
    verify("latch", t0, tdone, 17'd4);
    do_ack();

    // Start in RUN ignored; start+ack together in DONE returns to IDLE without restart
    start_frame(1'b1, 4'd8, t0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tdone);
    verify("spur", t0, tdone, 17'd4);
    start = 1'b1;
    ack   = 1'b1;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    chk("spur_idle_done", done, 1'b0);
    chk("spur_idle_busy", busy, 1'b0);
    clr_log();
    tick(); tick(); tick(); tick(); tick();
    chk("spur_no_restart_busy", busy, 1'b0);
    chk("spur_no_restart_wr", n_wr, 0);
    start_frame(1'b1, 4'd8, t0);
    wait_done(tdone);
    verify("second", t0, tdone, 17'd4);
    do_ack();

    // Asynchronous reset mid-RUN
    start_frame(1'b0, 4'd8, t0);
    tick(); tick(); tick(); tick();
    chk("mid_we_before", wr_we, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_we",   wr_we, 1'b0);
    chk("mid_rst_busy", busy,  1'b0);
    tick();
    reset = 1'b1;
    clr_log();
    for (int k = 0; k < 20; k++) tick();
    chk("mid_post_wr",   n_wr, 0);
    chk("mid_post_busy", busy, 1'b0);
    chk("mid_post_done", done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
